seg7_display_ctrl: RTL and testbench
====================================

SEG7_DISPLAY_CTRL -- requirements
Module: seg7_display_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000: clock cycles per blink half-period.
REQ-002 SHALL have parameter LAMP_CYCLES, default 50000000: length of the lamp-test phase in clock cycles.
REQ-003 SHALL have port clkIn, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port nRstIn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports reqAIn/reqBIn, input, 1 bit each: write request from requester A/B.
REQ-006 SHALL have ports addrAIn/addrBIn, input, 2 bits each: target; 0..2 = display byte 0..2, 3 = control register.
REQ-007 SHALL have ports dataAIn/dataBIn, input, 8 bits each: write data.
REQ-008 SHALL have ports ackAOut/ackBOut, output, 1 bit each: write-accepted pulse.
REQ-009 SHALL have port lampTestReqIn, input, 1 bit: restart the lamp test.
REQ-010 SHALL have port lampTestOut, output, 1 bit: high while in LAMP_TEST.
REQ-011 SHALL have port byteEnableOut, output, 3 bits: per-byte enable for the 7-segment driver.
REQ-012 SHALL have port byteDataOut, output, 24 bits: hex digits for the driver; byte n = bits [8n+7:8n].

Function
REQ-013 SHALL implement FSM states LAMP_TEST and RUN.
REQ-014 In LAMP_TEST: lampCnt counts 0..LAMP_CYCLES-1; the edge at which lampCnt==LAMP_CYCLES-1 moves to RUN and clears lampCnt.
REQ-015 In LAMP_TEST: byteEnableOut=3'b111, byteDataOut=24'h888888, no ack issued, requests stay pending.
REQ-016 In RUN, lampTestReqIn=1 at an edge: enter LAMP_TEST, lampCnt=0; no write accepted at that edge (lamp test wins over simultaneous requests).
REQ-017 In LAMP_TEST, lampTestReqIn: ignored (no counter restart).
REQ-018 Eligibility: requester X is eligible when reqXIn=1 and ackXOut=0 (prevents double-accept of one request).
REQ-019 Arbitration in RUN, one write per edge: only one eligible -> grant it; both eligible -> grant the one rrPtr selects; after any grant rrPtr points to the other requester.
REQ-020 Grant at edge N: ackXOut=1 for exactly the cycle after edge N, then 0; the write takes effect at edge N.
REQ-021 Requester SHALL hold addr/data stable while req high until it sees ack; it may keep req high for back-to-back writes (max one write per 2 cycles per requester).
REQ-022 Write to addr 0..2: dataReg byte n <= data[7:0].
REQ-023 Write to addr 3: enReg <= data[2:0], blinkReg <= data[5:3]; data[7:6] ignored.
REQ-024 Blink: tickCnt counts 0..TICK_DIV-1 in RUN only (held at 0 in LAMP_TEST); at wrap, phase toggles.
REQ-025 In RUN: byteEnableOut[i] = enReg[i] & ~(blinkReg[i] & phase); byteDataOut = dataReg.
REQ-026 All outputs SHALL derive from registers only; there SHALL be no combinational input-to-output path.
REQ-027 Control writes SHALL NOT reset tickCnt or phase.

Reset
REQ-028 On nRstIn=0, immediately and independent of clkIn: state=LAMP_TEST, lampCnt=0, tickCnt=0, phase=0, rrPtr=A, ackAOut=ackBOut=0, dataReg=24'h000000, enReg=3'b111, blinkReg=3'b000.
REQ-029 During reset, outputs SHALL read byteEnableOut=3'b111, byteDataOut=24'h888888, lampTestOut=1.
REQ-030 Reset asserted mid-write or mid-lamp-test SHALL abort the operation; no ack is issued after reset.

Verification (TICK_DIV=4, LAMP_CYCLES=8)
REQ-031 Release reset, reqA high with addr0/data 8'h5A -> lampTestOut=1 for 8 edges, no ack; ackAOut=1 for the cycle after the first RUN edge; byteDataOut=24'h00005A.
REQ-032 Both requesters request every cycle (A addr1/8'h11, B addr2/8'h22) in RUN -> grants alternate A,B,A,B; each ack a one-cycle pulse; no requester acked on consecutive edges.
REQ-033 Write addr3 = 8'b00_001_011 -> byteEnableOut alternates 3'b011 / 3'b010 every 4 cycles, starting at 3'b011.
REQ-034 lampTestReqIn and reqBIn high on the same RUN edge -> no ackBOut; 24'h888888 for 8 cycles; B then acked; phase/tickCnt restart from 0.
REQ-035 Assert nRstIn mid-blink after 3 writes -> outputs immediately 3'b111/24'h888888; after the next lamp test, byteDataOut=24'h000000 and enReg=3'b111.

Source files
------------

// File: rtl/seg7_wr_if.sv
// Write port bundle for the two requesters of seg7_display_ctrl.
// Each requester drives req/addr/data and sees a one-cycle ack when its write lands.
interface seg7_wr_if;
    logic       reqAIn;
    logic [1:0] addrAIn;
    logic [7:0] dataAIn;
    logic       ackAOut;
    logic       reqBIn;
    logic [1:0] addrBIn;
    logic [7:0] dataBIn;
    logic       ackBOut;

    modport master (
        output reqAIn, addrAIn, dataAIn, reqBIn, addrBIn, dataBIn,
        input  ackAOut, ackBOut
    );

    modport slave (
        input  reqAIn, addrAIn, dataAIn, reqBIn, addrBIn, dataBIn,
        output ackAOut, ackBOut
    );
endinterface

// File: rtl/seg7_display_ctrl.sv
// 3-byte 7-segment display controller: lamp test after reset, then a dual-port
// round-robin register file with per-byte enable and blink.
module seg7_display_ctrl #(
    parameter int unsigned TICK_DIV    = 25000000,
    parameter int unsigned LAMP_CYCLES = 50000000
) (
    input  logic        clkIn,
    input  logic        nRstIn,
    seg7_wr_if.slave    wr,
    input  logic        lampTestReqIn,
    output logic        lampTestOut,
    output logic [2:0]  byteEnableOut,
    output logic [23:0] byteDataOut
);

    localparam int LAMP_W = $clog2(LAMP_CYCLES + 1);
    localparam int TICK_W = $clog2(TICK_DIV + 1);
    localparam logic [LAMP_W-1:0] LAMP_LAST = LAMP_W'(LAMP_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic {LAMP_TEST, RUN} state_t;
    typedef enum logic {RR_A, RR_B}     rr_t;

    state_t            state;
    rr_t               rr_ptr;
    logic [LAMP_W-1:0] lamp_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic              phase;
    logic              ack_a;
    logic              ack_b;
    logic [23:0]       data_reg;
    logic [2:0]        en_reg;
    logic [2:0]        blink_reg;

    logic       run_write;
    logic       elig_a;
    logic       elig_b;
    logic       grant_a;
    logic       grant_b;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;

    // A requester whose ack is currently high has already been served for this request.
    assign elig_a    = wr.reqAIn & ~ack_a;
    assign elig_b    = wr.reqBIn & ~ack_b;
    assign run_write = (state == RUN) & ~lampTestReqIn;
    assign grant_a   = run_write & elig_a & (~elig_b | (rr_ptr == RR_A));
    assign grant_b   = run_write & elig_b & ~grant_a;
    assign wr_addr   = grant_a ? wr.addrAIn : wr.addrBIn;
    assign wr_data   = grant_a ? wr.dataAIn : wr.dataBIn;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering-dependent races.
    always_ff @(posedge clkIn or negedge nRstIn) begin
        if (!nRstIn) begin
            state     <= LAMP_TEST;
            rr_ptr    <= RR_A;
            lamp_cnt  <= '0;
            tick_cnt  <= '0;
            phase     <= 1'b0;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            data_reg  <= 24'h000000;
            en_reg    <= 3'b111;
            blink_reg <= 3'b000;
        end else begin
            case (state)
                LAMP_TEST: begin
                    ack_a    <= 1'b0;
                    ack_b    <= 1'b0;
                    tick_cnt <= '0;
                    phase    <= 1'b0;
                    if (lamp_cnt == LAMP_LAST) begin
                        state    <= RUN;
                        lamp_cnt <= '0;
                    end else begin
                        lamp_cnt <= lamp_cnt + 1'b1;
                    end
                end

                RUN: begin
                    if (lampTestReqIn) begin
                        // Lamp test pre-empts any write presented on the same edge.
                        state    <= LAMP_TEST;
                        lamp_cnt <= '0;
                        ack_a    <= 1'b0;
                        ack_b    <= 1'b0;
                        tick_cnt <= '0;
                        phase    <= 1'b0;
                    end else begin
                        ack_a <= grant_a;
                        ack_b <= grant_b;
                        if (grant_a)      rr_ptr <= RR_B;
                        else if (grant_b) rr_ptr <= RR_A;

                        if (grant_a || grant_b) begin
                            case (wr_addr)
                                2'd0: data_reg[7:0]   <= wr_data;
                                2'd1: data_reg[15:8]  <= wr_data;
                                2'd2: data_reg[23:16] <= wr_data;
                                default: begin
                                    en_reg    <= wr_data[2:0];
                                    blink_reg <= wr_data[5:3];
                                end
                            endcase
                        end

                        // Blink timebase free-runs in RUN; control writes leave it alone.
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            phase    <= ~phase;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                default: state <= LAMP_TEST;
            endcase
        end
    end

    assign wr.ackAOut    = ack_a;
    assign wr.ackBOut    = ack_b;
    assign lampTestOut   = (state == LAMP_TEST);
    assign byteEnableOut = (state == LAMP_TEST) ? 3'b111
                         : (en_reg & ~(blink_reg & {3{phase}}));
    assign byteDataOut   = (state == LAMP_TEST) ? 24'h888888 : data_reg;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl with TICK_DIV=4, LAMP_CYCLES=8.
// Outputs are sampled 1 time unit after each rising edge.
module tb_seg7_display_ctrl;

    logic        clk;
    logic        rst_n;
    logic        lamp_req;
    logic        lamp_out;
    logic [2:0]  byte_en;
    logic [23:0] byte_data;
    int          total;
    int          bad;

    seg7_wr_if wr ();

    seg7_display_ctrl #(.TICK_DIV(4), .LAMP_CYCLES(8)) dut (
        .clkIn         (clk),
        .nRstIn        (rst_n),
        .wr            (wr.slave),
        .lampTestReqIn (lamp_req),
        .lampTestOut   (lamp_out),
        .byteEnableOut (byte_en),
        .byteDataOut   (byte_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        lamp_req   = 1'b0;
        wr.reqAIn  = 1'b0; wr.addrAIn = 2'd0; wr.dataAIn = 8'h00;
        wr.reqBIn  = 1'b0; wr.addrBIn = 2'd0; wr.dataBIn = 8'h00;

        // Reset values
        #3;
        check("rst_en",   byte_en,   3'b111);
        check("rst_data", byte_data, 24'h888888);
        check("rst_lamp", lamp_out,  1'b1);
        check("rst_ack",  {wr.ackAOut, wr.ackBOut}, 2'b00);

        // Request pending through the lamp test
        wr.reqAIn = 1'b1; wr.addrAIn = 2'd0; wr.dataAIn = 8'h5A;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("lamp1_%0d", i), lamp_out, (i < 8));
            check($sformatf("lamp1_ack_%0d", i), wr.ackAOut, 1'b0);
        end
        step();
        check("first_ack",  wr.ackAOut, 1'b1);
        check("first_data", byte_data,  24'h00005A);
        check("first_en",   byte_en,    3'b111);
        wr.reqAIn = 1'b0;
        step();
        check("first_ack_end", wr.ackAOut, 1'b0);

        // Both requesting continuously; pointer now favours B
        wr.reqAIn = 1'b1; wr.addrAIn = 2'd1; wr.dataAIn = 8'h11;
        wr.reqBIn = 1'b1; wr.addrBIn = 2'd2; wr.dataBIn = 8'h22;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("rr_a_%0d", k), wr.ackAOut, (k % 2 == 1));
            check($sformatf("rr_b_%0d", k), wr.ackBOut, (k % 2 == 0));
        end
        wr.reqAIn = 1'b0;
        wr.reqBIn = 1'b0;
        step();
        check("rr_idle", {wr.ackAOut, wr.ackBOut}, 2'b00);
        check("rr_data", byte_data, 24'h22115A);

        // Control write: en=011, blink=001
        wr.reqAIn = 1'b1; wr.addrAIn = 2'd3; wr.dataAIn = 8'b00_001_011;
        step();
        check("ctl_ack", wr.ackAOut, 1'b1);
        wr.reqAIn = 1'b0;
        step();
        check("ctl_ack_end", wr.ackAOut, 1'b0);

        // Lamp request wins over a simultaneous B request
        lamp_req = 1'b1;
        wr.reqBIn = 1'b1; wr.addrBIn = 2'd0; wr.dataBIn = 8'hC3;
        step();
        check("lt_enter",  lamp_out,   1'b1);
        check("lt_noack",  wr.ackBOut, 1'b0);
        check("lt_data",   byte_data,  24'h888888);
        check("lt_en",     byte_en,    3'b111);
        lamp_req = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            check($sformatf("lt_hold_%0d", i), lamp_out, 1'b1);
            check($sformatf("lt_ackb_%0d", i), wr.ackBOut, 1'b0);
            if (i == 3) lamp_req = 1'b1;
            if (i == 4) lamp_req = 1'b0;
        end

        // Blink pattern restarts at phase 0 on lamp exit
        for (int k = 0; k < 12; k++) begin
            step();
            check($sformatf("blink_%0d", k), byte_en, ((k / 4) % 2 == 1) ? 3'b010 : 3'b011);
            if (k == 0) begin
                check("run_again", lamp_out,   1'b0);
                check("b_wait",    wr.ackBOut, 1'b0);
            end
            if (k == 1) begin
                check("b_ack",  wr.ackBOut, 1'b1);
                check("b_data", byte_data,  24'h2211C3);
                wr.reqBIn = 1'b0;
            end
            if (k == 2) check("b_ack_end", wr.ackBOut, 1'b0);
        end

        // Asynchronous reset mid-blink with a write pending
        wr.reqAIn = 1'b1; wr.addrAIn = 2'd1; wr.dataAIn = 8'h77;
        #2 rst_n = 1'b0;
        #1;
        check("arst_en",   byte_en,   3'b111);
        check("arst_data", byte_data, 24'h888888);
        check("arst_lamp", lamp_out,  1'b1);
        check("arst_ack",  wr.ackAOut, 1'b0);
        wr.reqAIn = 1'b0;
        step();
        check("arst_hold_ack", wr.ackAOut, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("lamp2_%0d", i), lamp_out, (i < 8));
        end
        check("post_rst_data", byte_data, 24'h000000);
        check("post_rst_en",   byte_en,   3'b111);
        for (int i = 0; i < 5; i++) step();
        check("post_rst_en_blink", byte_en,    3'b111);
        check("post_rst_ack",      wr.ackAOut, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
